// File: rtl/led_fade_engine_pkg.sv
// Shared definitions for the LED fade engine: register map, CTRL bit layout,
// brightness type and the channel limit the register map is sized for.
`timescale 1ns/1ps
package led_pkg;

    typedef logic [7:0] brightness_t;

    localparam int MAX_CH = 10;

    localparam logic [4:0] ADDR_TARGET0  = 5'd0;
    localparam logic [4:0] ADDR_CURRENT0 = 5'd10;
    localparam logic [4:0] ADDR_STEP     = 5'd20;
    localparam logic [4:0] ADDR_PRESC    = 5'd21;
    localparam logic [4:0] ADDR_STATUS   = 5'd22;
    localparam logic [4:0] ADDR_CTRL     = 5'd23;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_SNAP_BIT = 1;

endpackage

// File: rtl/led_fade_engine_if.sv
// Device bus for the fade engine: CPU (master) drives address/strobe/data,
// the engine (slave) returns registered read data.
`timescale 1ns/1ps
interface led_fade_engine_if;
    logic [4:0] address;
    logic       enable;
    logic       mode;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output address, output enable, output mode, output data_in,
                    input data_out);
    modport slave  (input address, input enable, input mode, input data_in,
                    output data_out);
endinterface

// File: rtl/led_fade_engine_tick_gen.sv
// Fade tick prescaler: a fixed BASE_DIV pre-divider followed by a
// programmable 0..presc stage. tick is a single-clk strobe.
`timescale 1ns/1ps
module fade_tick_gen #(
    parameter int BASE_DIV = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic [7:0] presc,
    output logic       tick
);
    localparam int PRE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       main_cnt;

    assign tick = run && (pre_cnt == PRE_LAST) && (main_cnt == presc);

    // Both counters advance only while running; a PRESC write restarts the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            main_cnt <= '0;
        end else if (clear) begin
            pre_cnt  <= '0;
            main_cnt <= '0;
        end else if (run) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt  <= '0;
                main_cnt <= (main_cnt == presc) ? 8'd0 : main_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_fade_engine.sv
// Bus-mapped brightness sequencer: ramps each channel's current level toward
// its target by STEP on every fade tick; level feeds the PWM duty inputs.
`timescale 1ns/1ps
module led_fade_engine
    import led_pkg::*;
#(
    parameter int NUM_CH   = 10,
    parameter int BASE_DIV = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    led_fade_engine_if.slave   bus,
    output brightness_t        level [NUM_CH],
    output logic               fade_done
);
    logic        wr_en, rd_en, snap, presc_clear, tick, busy;
    logic [7:0]  step_reg, presc_reg, rd_data;
    logic        run_reg, busy_reg;
    brightness_t target [NUM_CH];
    logic [NUM_CH-1:0] ch_busy;

    assign wr_en       = bus.enable & bus.mode;
    assign rd_en       = bus.enable & ~bus.mode;
    assign snap        = wr_en && (bus.address == ADDR_CTRL) && bus.data_in[CTRL_SNAP_BIT];
    assign presc_clear = wr_en && (bus.address == ADDR_PRESC);
    assign busy        = |ch_busy;

    fade_tick_gen #(.BASE_DIV(BASE_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_reg),
        .clear (presc_clear),
        .presc (presc_reg),
        .tick  (tick)
    );

    // Global control registers; snap is an action, not stored state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_reg  <= 8'd1;
            presc_reg <= 8'd0;
            run_reg   <= 1'b1;
        end else if (wr_en) begin
            if (bus.address == ADDR_STEP)  step_reg  <= bus.data_in;
            if (bus.address == ADDR_PRESC) presc_reg <= bus.data_in;
            if (bus.address == ADDR_CTRL)  run_reg   <= bus.data_in[CTRL_RUN_BIT];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [4:0] TGT_ADDR = ADDR_TARGET0 + 5'(gi);
            localparam logic [4:0] CUR_ADDR = ADDR_CURRENT0 + 5'(gi);

            brightness_t tgt, cur, stepped;
            logic [8:0]  up_sum, down_diff;

            // 9-bit arithmetic so overshoot/borrow is visible and clamps to target.
            assign up_sum    = {1'b0, cur} + {1'b0, step_reg};
            assign down_diff = {1'b0, cur} - {1'b0, step_reg};

            // One fade step toward the (pre-edge) target.
            always_comb begin
                stepped = cur;
                if (cur < tgt) begin
                    stepped = (up_sum > {1'b0, tgt}) ? tgt : up_sum[7:0];
                end else if (cur > tgt) begin
                    stepped = (down_diff[8] || (down_diff[7:0] < tgt)) ? tgt : down_diff[7:0];
                end
            end

            // Target register; a same-cycle tick still sees the old value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                 tgt <= '0;
                else if (wr_en && bus.address == TGT_ADDR)  tgt <= bus.data_in;
            end

            // Current level: direct write beats snap beats tick.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                 cur <= '0;
                else if (wr_en && bus.address == CUR_ADDR)  cur <= bus.data_in;
                else if (snap)                              cur <= tgt;
                else if (tick)                              cur <= stepped;
            end

            assign target[gi]  = tgt;
            assign level[gi]   = cur;
            assign ch_busy[gi] = (cur != tgt);
        end
    endgenerate

    // Read mux; unmapped and out-of-range channel addresses read as zero.
    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_STEP:   rd_data = step_reg;
            ADDR_PRESC:  rd_data = presc_reg;
            ADDR_STATUS: rd_data = {7'd0, busy};
            ADDR_CTRL:   rd_data = {7'd0, run_reg};
            default:     rd_data = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.address == ADDR_TARGET0 + 5'(i))  rd_data = target[i];
            if (bus.address == ADDR_CURRENT0 + 5'(i)) rd_data = level[i];
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bus.data_out <= '0;
        else if (rd_en) bus.data_out <= rd_data;
    end

    // fade_done pulses one clk after busy falls, whatever made it fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg  <= 1'b0;
            fade_done <= 1'b0;
        end else begin
            busy_reg  <= busy;
            fade_done <= busy_reg & ~busy;
        end
    end
endmodule

// File: doc/led_fade_engine.md
Name: led_fade_engine

Overview:
Bus-mapped brightness sequencer directly upstream of the LED PWM/gamma stage. It holds a per-channel target brightness and ramps a per-channel current brightness toward that target at a programmable rate. The current brightness bytes drive the PWM stage's duty inputs. The CPU sets targets over the 5-bit device bus and polls status; the fades then run without further CPU involvement.

Parameters:
NUM_CH, 10, number of brightness channels (max 10; register map is fixed to this limit)
BASE_DIV, 256, fixed clk pre-divider; one fade tick every BASE_DIV*(PRESC+1) clks

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
address  in  5  device register address
enable  in  1  bus access strobe for this device
mode  in  1  1 = write, 0 = read
data_in  in  8  write data
data_out  out  8  registered read data
level  out  NUM_CH x 8  current brightness per channel, to PWM stage duty inputs
fade_done  out  1  one-clk pulse when all channels reach target

Behaviour:
- Register map:
  - 0..9 TARGET[i] R/W
  - 10..19 CURRENT[i]: read returns level; write forces current, target unchanged
  - 20 STEP R/W
  - 21 PRESC R/W
  - 22 STATUS RO: bit0 busy = any current != target; other bits 0
  - 23 CTRL R/W: bit0 run, bit1 snap. Snap is write-only and self-clears.
  - 24..31: reads return 0, writes are ignored.
  - Addresses for i >= NUM_CH behave as unmapped.
- Reset values: all TARGET/CURRENT 0; STEP 1; PRESC 0; CTRL run = 1; data_out 0; level 0; fade_done 0; prescaler counters 0.
- Bus:
  - Access occurs only when enable = 1.
  - Write takes effect at the clk edge.
  - Read: data_out is updated at the edge after enable & !mode and holds until the next read (1-clk latency).
  - Read-after-write of the same address in consecutive cycles returns the new value.
- Tick generator:
  - Two counters: pre (0..BASE_DIV-1) and main (0..PRESC).
  - tick = 1 for one clk when pre = BASE_DIV-1 and main = PRESC; both counters then wrap to 0.
  - Counters run only while run = 1 and hold their value while run = 0.
  - A write to PRESC clears both counters.
- Fade step, per channel on tick:
  - If cur < tgt: cur = min(cur + STEP, tgt).
  - If cur > tgt: cur = max(cur - STEP, tgt).
  - Otherwise cur is unchanged.
  - Arithmetic is 9-bit, so there is no wrap: 250 + 10 toward 255 yields 255; 5 - 10 toward 0 yields 0.
  - STEP = 0 means no motion; busy may stay 1.
- Snap: a write to CTRL with bit1 = 1 sets every cur = tgt in that cycle.
- Simultaneous events, in priority order:
  - A CURRENT[i] write beats the tick update for channel i.
  - A TARGET[i] write in a tick cycle: the tick uses the old target, and the new target applies from the next tick.
  - Snap beats tick.
- fade_done: asserted for 1 clk in the cycle after busy falls 1 -> 0. Any cause (tick, snap, CURRENT write) qualifies. It is not asserted out of reset.
- Reset mid-fade: everything returns to reset values immediately (asynchronous); fade_done is not pulsed.
- level is registered and equals the CURRENT registers directly; no extra latency.

Decomposition:
- Package led_pkg:
  - Register address localparams (ADDR_TARGET0 = 0, ADDR_CURRENT0 = 10, ADDR_STEP = 20, ADDR_PRESC = 21, ADDR_STATUS = 22, ADDR_CTRL = 23)
  - CTRL bit indices
  - typedef brightness_t (logic [7:0])
  - MAX_CH = 10
- Sub-module fade_tick_gen: the pre/main prescaler. Inputs are run, presc, clear; output is tick.
- Per-channel step logic is an in-module generate loop.

Test Plan:
1. Reset release, then read addresses 20, 22, 23 -> data_out 0x01, 0x00, 0x01 one clk after each read; level all 0; fade_done stays 0.
2. BASE_DIV = 4 (test override), PRESC 0, STEP 5, write TARGET[0] = 12 -> level[0] is 5 at 4 clks, 10 at 8 clks, 12 at 12 clks; STATUS busy = 1 until 12 is reached; fade_done pulses once at 13 clks.
3. CURRENT[3] = 250, STEP 10, TARGET[3] = 255 -> one tick gives 255, no wrap. Then TARGET[3] = 0, STEP 200 -> 55, then 0.
4. Write CURRENT[1] = 77 in the same clk as a tick while ramping -> level[1] = 77 (write wins). In a separate tick cycle, write TARGET[1] -> that tick moves toward the old target.
5. run = 0 mid-fade -> level frozen for 100 clks and the prescaler holds. Then run = 1 -> resumes; the first tick arrives after the remaining count, not a full period.
6. Fade in progress, then assert rst_n = 0 asynchronously between edges -> level, data_out, STEP, and CTRL return to reset values immediately; fade_done is never pulsed. A write to address 30 has no effect and reads back 0.
